sram_arbiter: RTL and testbench

//  Two-port round-robin arbiter and strobe sequencer for the 8-bit sram block (dout/din/addr/wr/rd/cs).

---
 rtl/sram_arbiter_pkg.sv | 21 ++
 rtl/sram_arbiter_rr_arb2.sv | 33 +++
 rtl/sram_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state codes, port identifiers
// and default geometry.
package sram_arbiter_pkg;

  localparam int unsigned AW_DEF       = 8;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned STRB_CYC_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin grant. The grant is combinational from the requests and
// the last-served pointer; the pointer advances when the grant is taken.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt_c,
  output port_e      o_last
);

  always_comb begin
    o_gnt_c = 2'b00;
    case (i_req)
      2'b01:   o_gnt_c = 2'b01;
      2'b10:   o_gnt_c = 2'b10;
      2'b11:   o_gnt_c = (o_last == PORT_B) ? 2'b01 : 2'b10;
      default: o_gnt_c = 2'b00;
    endcase
  end

  // Pointer resets to B so that A wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_last <= PORT_B;
    end else if (i_update) begin
      o_last <= (o_gnt_c == 2'b10) ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for an 8-bit SRAM:
// IDLE -> SETUP -> STROBE (STRB_CYC cycles) -> DONE, all outputs registered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned STRB_CYC = STRB_CYC_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_ack,
  output logic [DW-1:0] o_a_rdata,
  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_ack,
  output logic [DW-1:0] o_b_rdata,
  output logic          o_busy,
  output logic          o_sram_cs,
  output logic          o_sram_wr,
  output logic          o_sram_rd,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_din,
  input  logic [DW-1:0] i_sram_dout
);

  localparam int unsigned CW = $clog2(STRB_CYC + 1);

  state_e        r_state;
  logic          r_we;
  logic [CW-1:0] r_cnt;
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_update;
  logic          w_sel_b;
  port_e         w_last;

  assign w_req    = {i_b_req, i_a_req};
  assign w_update = (r_state == ST_IDLE) && (w_req != 2'b00);
  assign w_sel_b  = (w_gnt == 2'b10);

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (w_req),
    .i_update (w_update),
    .o_gnt_c  (w_gnt),
    .o_last   (w_last)
  );

  // The pointer holds the granted port for the whole transaction, so it
  // also steers the ack and read data in STROBE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      o_a_ack     <= 1'b0;
      o_b_ack     <= 1'b0;
      o_a_rdata   <= '0;
      o_b_rdata   <= '0;
      o_busy      <= 1'b0;
      o_sram_cs   <= 1'b0;
      o_sram_wr   <= 1'b0;
      o_sram_rd   <= 1'b0;
      o_sram_addr <= '0;
      o_sram_din  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_update) begin
            r_we        <= w_sel_b ? i_b_we    : i_a_we;
            o_sram_addr <= w_sel_b ? i_b_addr  : i_a_addr;
            o_sram_din  <= w_sel_b ? i_b_wdata : i_a_wdata;
            o_sram_cs   <= 1'b1;
            o_busy      <= 1'b1;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          o_sram_wr <= r_we;
          o_sram_rd <= ~r_we;
          r_cnt     <= CW'(STRB_CYC - 1);
          r_state   <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            o_sram_wr <= 1'b0;
            o_sram_rd <= 1'b0;
            if (w_last == PORT_B) begin
              o_b_ack <= 1'b1;
              if (!r_we) o_b_rdata <= i_sram_dout;
            end else begin
              o_a_ack <= 1'b1;
              if (!r_we) o_a_rdata <= i_sram_dout;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          o_a_ack   <= 1'b0;
          o_b_ack   <= 1'b0;
          o_sram_cs <= 1'b0;
          o_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the pins, a transaction-level
// reference model, directed scenarios and a randomized two-requester phase.
module tb_sram_arbiter;

  localparam int unsigned STRB   = 2;
  localparam int          LAST_T = STRB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       p_req [2];
  logic       p_we  [2];
  logic [7:0] p_addr[2];
  logic [7:0] p_wd  [2];

  logic       a_ack, b_ack, busy, cs, wr, rd;
  logic [7:0] a_rdata, b_rdata, s_addr, s_din, s_dout;

  sram_arbiter #(.AW(8), .DW(8), .STRB_CYC(STRB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_a_req     (p_req[0]),
    .i_a_we      (p_we[0]),
    .i_a_addr    (p_addr[0]),
    .i_a_wdata   (p_wd[0]),
    .o_a_ack     (a_ack),
    .o_a_rdata   (a_rdata),
    .i_b_req     (p_req[1]),
    .i_b_we      (p_we[1]),
    .i_b_addr    (p_addr[1]),
    .i_b_wdata   (p_wd[1]),
    .o_b_ack     (b_ack),
    .o_b_rdata   (b_rdata),
    .o_busy      (busy),
    .o_sram_cs   (cs),
    .o_sram_wr   (wr),
    .o_sram_rd   (rd),
    .o_sram_addr (s_addr),
    .o_sram_din  (s_din),
    .i_sram_dout (s_dout)
  );

  // Behavioural SRAM attached to the pins
  logic [7:0] sram_mem [256] = '{default: 8'h00};
  assign s_dout = sram_mem[s_addr];
  always @(posedge clk) if (cs && wr) sram_mem[s_addr] <= s_din;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: m_t counts cycles since the grant (0 = idle).
  int         m_t = 0;
  int         m_port = 0;
  int         m_last = 1;
  bit         m_we = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wd = 8'h00;
  logic [7:0] m_rdata[2] = '{8'h00, 8'h00};
  logic [7:0] m_mem[256] = '{default: 8'h00};

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_last = 1; m_we = 1'b0; m_addr = 8'h00; m_wd = 8'h00;
      m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    end else if (m_t == 0) begin
      if (p_req[0] || p_req[1]) begin
        if (p_req[0] && p_req[1]) m_port = (m_last == 1) ? 0 : 1;
        else                      m_port = p_req[0] ? 0 : 1;
        m_last = m_port;
        m_we   = p_we[m_port];
        m_addr = p_addr[m_port];
        m_wd   = p_wd[m_port];
        m_t    = 1;
      end
    end else if (m_t == LAST_T) begin
      m_t = 0;
    end else begin
      m_t++;
      if (m_t == LAST_T) begin
        if (m_we) m_mem[m_addr] = m_wd;
        else      m_rdata[m_port] = m_mem[m_addr];
      end
    end
    cyc++;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      bit strobe;
      strobe = (m_t >= 2) && (m_t <= LAST_T - 1);
      chk("busy",      32'(busy),    32'(m_t != 0));
      chk("sram_cs",   32'(cs),      32'(m_t != 0));
      chk("sram_wr",   32'(wr),      32'(strobe && m_we));
      chk("sram_rd",   32'(rd),      32'(strobe && !m_we));
      chk("a_ack",     32'(a_ack),   32'(m_t == LAST_T && m_port == 0));
      chk("b_ack",     32'(b_ack),   32'(m_t == LAST_T && m_port == 1));
      chk("sram_addr", 32'(s_addr),  32'(m_addr));
      chk("sram_din",  32'(s_din),   32'(m_wd));
      chk("a_rdata",   32'(a_rdata), 32'(m_rdata[0]));
      chk("b_rdata",   32'(b_rdata), 32'(m_rdata[1]));
      chk("exclusive", 32'(!(wr && rd) && !(a_ack && b_ack) && !((wr || rd) && !cs)), 32'd1);
    end
  end

  // Observations from one directed transaction, indexed by cycle after grant
  logic       ob_cs[5], ob_wr[5], ob_rd[5], ob_ack[5];
  logic [7:0] ob_addr[5], ob_din[5], ob_rdata[5], ob_xrdata[5];

  // Called at posedge+1 with the DUT idle; the grant happens on the next edge.
  task automatic run_txn(input int p, input bit we, input logic [7:0] addr, input logic [7:0] wd,
                         input bit mod_c1, input logic [7:0] addr2);
    p_we[p] = we; p_addr[p] = addr; p_wd[p] = wd; p_req[p] = 1'b1;
    @(posedge clk); #1;
    if (mod_c1) begin p_addr[p] = addr2; p_req[p] = 1'b0; end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ob_cs[k] = cs; ob_wr[k] = wr; ob_rd[k] = rd; ob_addr[k] = s_addr; ob_din[k] = s_din;
      ob_ack[k]    = (p == 1) ? b_ack : a_ack;
      ob_rdata[k]  = (p == 1) ? b_rdata : a_rdata;
      ob_xrdata[k] = (p == 1) ? a_rdata : b_rdata;
    end
    @(posedge clk); #1;
    p_req[p] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic new_fields(input int p);
    p_we[p]   = 1'($urandom_range(0, 1));
    p_addr[p] = 8'($urandom_range(0, 15));
    p_wd[p]   = 8'($urandom);
  endtask

  int ack_cyc[4];
  int ack_port[4];
  bit seen[2];

  initial begin
    // Reset with both requests already high; they stay high for the alternation run
    rst = 1'b1;
    p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 8'h40; p_wd[0] = 8'h11;
    p_req[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 8'h41; p_wd[1] = 8'h22;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cs",   32'(cs),   32'd0);
      chk("rst_ack",  32'(a_ack || b_ack), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy || a_ack || b_ack), 32'd0);

    begin
      int n = 0;
      int budget = 0;
      while (n < 4 && budget < 40) begin
        @(negedge clk);
        budget++;
        if (a_ack || b_ack) begin
          ack_port[n] = b_ack ? 1 : 0;
          ack_cyc[n]  = cyc;
          n++;
        end
      end
      @(posedge clk); #1;
      p_req[0] = 1'b0; p_req[1] = 1'b0;
      chk("alt_ack_count", 32'(n), 32'd4);
      for (int i = 0; i < n; i++) begin
        chk("alt_order", 32'(ack_port[i]), 32'(i % 2));
        if (i > 0) chk("alt_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
      end
    end
    @(posedge clk); #1;

    // A write 0x12 <- 0xA5
    run_txn(0, 1'b1, 8'h12, 8'hA5, 1'b0, 8'h00);
    chk("w_c1_cs",   32'(ob_cs[1]),   32'd1);
    chk("w_c1_addr", 32'(ob_addr[1]), 32'h12);
    chk("w_c1_din",  32'(ob_din[1]),  32'hA5);
    chk("w_c1_wr",   32'(ob_wr[1]),   32'd0);
    chk("w_c2_wr",   32'(ob_wr[2]),   32'd1);
    chk("w_c3_wr",   32'(ob_wr[3]),   32'd1);
    chk("w_c3_ack",  32'(ob_ack[3]),  32'd0);
    chk("w_c4_ack",  32'(ob_ack[4]),  32'd1);
    chk("w_c4_wr",   32'(ob_wr[4]),   32'd0);
    chk("w_no_rd",   32'(ob_rd[1] | ob_rd[2] | ob_rd[3] | ob_rd[4]), 32'd0);

    // B read 0x12
    run_txn(1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00);
    chk("r_c2_rd",    32'(ob_rd[2]),    32'd1);
    chk("r_c3_rd",    32'(ob_rd[3]),    32'd1);
    chk("r_c4_ack",   32'(ob_ack[4]),   32'd1);
    chk("r_c4_rdata", 32'(ob_rdata[4]), 32'hA5);
    chk("r_a_rdata",  32'(ob_xrdata[4]), 32'h00);

    // Reset during the second strobe cycle of an A write
    p_we[0] = 1'b1; p_addr[0] = 8'h55; p_wd[0] = 8'h66; p_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pre_wr", 32'(wr), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; p_req[0] = 1'b0;
    @(negedge clk);
    chk("abort_cs",  32'(cs),    32'd0);
    chk("abort_wr",  32'(wr),    32'd0);
    chk("abort_ack", 32'(a_ack), 32'd0);
    @(posedge clk); #1;
    run_txn(1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00);
    chk("after_abort_ack",   32'(ob_ack[4]),   32'd1);
    chk("after_abort_rdata", 32'(ob_rdata[4]), 32'hA5);

    // A read 0x30 with address change and req drop during SETUP
    run_txn(0, 1'b0, 8'h30, 8'h00, 1'b1, 8'h31);
    chk("hold_c1_addr", 32'(ob_addr[1]), 32'h30);
    chk("hold_c3_addr", 32'(ob_addr[3]), 32'h30);
    chk("hold_c4_addr", 32'(ob_addr[4]), 32'h30);
    chk("hold_c4_ack",  32'(ob_ack[4]),  32'd1);
    chk("hold_rdata",   32'(ob_rdata[4]), 32'h00);

    // Randomized requesters; resets avoided while a write strobe is on the pins
    seen[0] = 1'b0; seen[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      seen[0] = a_ack; seen[1] = b_ack;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0) && !(m_we && m_t >= 2 && m_t <= LAST_T - 1);
      for (int p = 0; p < 2; p++) begin
        if (p_req[p] && seen[p]) begin
          p_req[p] = 1'($urandom_range(0, 1));
          if (p_req[p]) new_fields(p);
        end else if (!p_req[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            p_req[p] = 1'b1;
            new_fields(p);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          new_fields(p);
        end else if ($urandom_range(0, 39) == 0) begin
          p_req[p] = 1'b0;
        end
      end
    end
    rst = 1'b0; p_req[0] = 1'b0; p_req[1] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
